// File: rtl/hack_control_unit.sv
// Hack CPU control unit: multi-cycle FSM that sequences instruction fetch,
// optional data read, one ALU cycle, optional data write and register commit.
// The ALU and both memories are external; this block owns A, D, PC, IR, etc.
module hack_control_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        dmem_rd_req,
  output logic        dmem_wr_req,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_result,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [15:0] pc
);

  typedef enum logic [2:0] {
    FETCH, DECODE, MEMRD, EXEC, MEMWR, COMMIT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, d_q, pc_q, ir_q, m_q, res_q;
  logic        zr_q, ng_q;
  logic        jump_taken;

  // IR[14:13] carry no meaning for the control unit
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir_q[14:13];

  assign jump_taken = (ir_q[2] & ng_q) | (ir_q[1] & zr_q) | (ir_q[0] & ~zr_q & ~ng_q);

  // Addresses and data come straight from registers, so they are stable
  // for as long as a request waits for its ack.
  assign pc         = pc_q;
  assign imem_addr  = pc_q;
  assign dmem_addr  = a_q;
  assign dmem_wdata = res_q;
  assign alu_x      = d_q;
  assign alu_y      = ir_q[12] ? m_q : a_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next state and request/ALU-control outputs; requests are gated by reset
  // so they drop immediately, not at the next edge.
  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    dmem_rd_req = 1'b0;
    dmem_wr_req = 1'b0;
    {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = 6'b0;
    case (state_q)
      FETCH: begin
        imem_req = ~reset;
        if (imem_ack) state_d = DECODE;
      end
      DECODE: begin
        if (!ir_q[15])     state_d = FETCH;
        else if (ir_q[12]) state_d = MEMRD;
        else               state_d = EXEC;
      end
      MEMRD: begin
        dmem_rd_req = ~reset;
        if (dmem_ack) state_d = EXEC;
      end
      EXEC: begin
        {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir_q[11:6];
        state_d = ir_q[3] ? MEMWR : COMMIT;
      end
      MEMWR: begin
        dmem_wr_req = ~reset;
        if (dmem_ack) state_d = COMMIT;
      end
      COMMIT:  state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Architectural and pipeline registers, updated by the owning state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      a_q   <= '0;
      d_q   <= '0;
      ir_q  <= '0;
      m_q   <= '0;
      res_q <= '0;
      zr_q  <= 1'b0;
      ng_q  <= 1'b0;
    end else begin
      case (state_q)
        FETCH:  if (imem_ack) ir_q <= imem_rdata;
        DECODE: if (!ir_q[15]) begin
          a_q  <= ir_q;
          pc_q <= pc_q + 16'd1;
        end
        MEMRD:  if (dmem_ack) m_q <= dmem_rdata;
        EXEC: begin
          res_q <= alu_result;
          zr_q  <= alu_zr;
          ng_q  <= alu_ng;
        end
        COMMIT: begin
          if (ir_q[5]) a_q <= res_q;
          if (ir_q[4]) d_q <= res_q;
          // jump target is the A value from before this commit
          pc_q <= jump_taken ? a_q : pc_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_control_unit.sv
// Bench for hack_control_unit: an ISA-level Hack model (A, D, PC, memory)
// predicts every fetch address, data access and ALU operand; the bench also
// plays the ALU and both memories with random ack delays.
module tb_hack_control_unit;
  logic        clk, reset;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr, imem_rdata;
  logic        dmem_rd_req, dmem_wr_req, dmem_ack;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [15:0] alu_x, alu_y, alu_result, pc;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] m_a, m_d, m_pc;
  logic [15:0] obs_x, obs_y, obs_wa, obs_wd, obs_ra;
  int          rd_cnt;

  hack_control_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_rd_req(dmem_rd_req), .dmem_wr_req(dmem_wr_req), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .alu_x(alu_x), .alu_y(alu_y), .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
    .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
    .alu_result(alu_result), .alu_zr(alu_zr), .alu_ng(alu_ng), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hack ALU: c = {zx,nx,zy,ny,f,no}
  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, r;
    xx = c[5] ? 16'd0 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'd0 : y;
    yy = c[2] ? ~yy : yy;
    r  = c[1] ? xx + yy : xx & yy;
    return c[0] ? ~r : r;
  endfunction

  assign alu_result = hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
  assign alu_zr     = (alu_result == 16'd0);
  assign alu_ng     = alu_result[15];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic req_of(input int which);
    case (which)
      0:       return imem_req;
      1:       return dmem_rd_req;
      default: return dmem_wr_req;
    endcase
  endfunction

  function automatic logic [15:0] idle_vec;
    return 16'({imem_req, dmem_rd_req, dmem_wr_req,
                alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
  endfunction

  task automatic wait_for(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_of(which)) begin ok = 1'b1; return; end
      tick();
    end
    chk("req_timeout", 16'(req_of(which)), 16'd1);
  endtask

  // Hold a pending request for a random number of cycles, checking it stays put
  task automatic stall(input int which, input logic [15:0] addr);
    int dly;
    dly = $urandom_range(0, 2);
    repeat (dly) begin
      tick();
      chk("req_hold", 16'(req_of(which)), 16'd1);
      chk("addr_hold", (which == 0) ? imem_addr : dmem_addr, addr);
    end
  endtask

  // Run one instruction; entered and left on a negedge while the DUT fetches
  task automatic run_instr(input logic [15:0] ins);
    bit ok;
    logic [15:0] yv, res, olda;
    bit taken;
    wait_for(0, ok);
    if (!ok) return;
    chk("fetch_addr", imem_addr, m_pc);
    chk("fetch_excl", 16'({dmem_rd_req, dmem_wr_req}), 16'd0);
    stall(0, m_pc);
    imem_ack = 1'b1; imem_rdata = ins;
    tick();
    imem_ack = 1'b0; imem_rdata = 16'($urandom);
    chk("decode_idle", idle_vec(), 16'd0);
    // stray acks with nothing pending must be ignored
    if ($urandom_range(0, 1) == 1) begin imem_ack = 1'b1; dmem_ack = 1'b1; end
    tick();
    imem_ack = 1'b0; dmem_ack = 1'b0;
    if (!ins[15]) begin
      m_a  = ins;
      m_pc = m_pc + 16'd1;
      return;
    end
    if (ins[12]) begin
      wait_for(1, ok);
      if (!ok) return;
      chk("rd_addr", dmem_addr, m_a);
      obs_ra = dmem_addr;
      rd_cnt++;
      stall(1, m_a);
      dmem_rdata = mem[m_a]; dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0; dmem_rdata = 16'($urandom);
    end
    yv = ins[12] ? mem[m_a] : m_a;
    chk("exec_x", alu_x, m_d);
    chk("exec_y", alu_y, yv);
    chk("exec_ctrl", 16'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 16'(ins[11:6]));
    chk("exec_idle", 16'({imem_req, dmem_rd_req, dmem_wr_req}), 16'd0);
    obs_x = alu_x; obs_y = alu_y;
    res = hack_alu(m_d, yv, ins[11:6]);
    tick();
    if (ins[3]) begin
      wait_for(2, ok);
      if (!ok) return;
      chk("wr_addr", dmem_addr, m_a);
      chk("wr_data", dmem_wdata, res);
      obs_wa = dmem_addr; obs_wd = dmem_wdata;
      stall(2, m_a);
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      mem[m_a] = res;
    end
    chk("commit_idle", idle_vec(), 16'd0);
    tick();
    taken = (ins[2] && res[15]) || (ins[1] && res == 16'd0) ||
            (ins[0] && res != 16'd0 && !res[15]);
    olda = m_a;
    if (ins[5]) m_a = res;
    if (ins[4]) m_d = res;
    m_pc = taken ? olda : m_pc + 16'd1;
  endtask

  task automatic model_reset;
    m_a = 16'd0; m_d = 16'd0; m_pc = 16'h0000;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    logic [15:0] ins;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    imem_rdata = 16'd0; dmem_rdata = 16'd0; rd_cnt = 0;
    obs_x = 0; obs_y = 0; obs_wa = 0; obs_wd = 0; obs_ra = 0;
    model_reset();
    repeat (3) tick();
    chk("rst_idle", idle_vec(), 16'd0);
    chk("rst_pc", pc, 16'h0000);
    reset = 1'b0;
    #1;
    chk("post_rst_req", 16'(imem_req), 16'd1);
    chk("post_rst_addr", imem_addr, 16'h0000);
    tick();

    // @5, D=A, @7, D=D+A
    run_instr(16'h0005); run_instr(16'hEC10); run_instr(16'h0007); run_instr(16'hE090);
    chk("prog_pc", pc, 16'd4);
    run_instr(16'hE300);
    chk("prog_d", obs_x, 16'd12);
    chk("prog_a", obs_y, 16'd7);

    // M=D with A=100, D=3
    run_instr(16'h0003); run_instr(16'hEC10); run_instr(16'h0064); run_instr(16'hE308);
    chk("mwr_addr", obs_wa, 16'd100);
    chk("mwr_data", obs_wd, 16'd3);
    run_instr(16'hE300);
    chk("mwr_d_kept", obs_x, 16'd3);

    // D=M+1 with A=20, mem[20]=9
    mem[20] = 16'd9; rd_cnt = 0;
    run_instr(16'd20); run_instr(16'hFDD0);
    chk("mrd_count", 16'(rd_cnt), 16'd1);
    chk("mrd_addr", obs_ra, 16'd20);
    run_instr(16'hE300);
    chk("mrd_d", obs_x, 16'd10);

    // JEQ taken, JGT not taken, with D=0
    run_instr(16'h0000); run_instr(16'hEC10); run_instr(16'h0040); run_instr(16'hE302);
    chk("jeq_pc", pc, 16'h0040);
    run_instr(16'h0040); run_instr(16'hE301);
    chk("jgt_pc", pc, 16'h0042);

    // AM=M-1;JMP with A=8, M=5
    mem[8] = 16'd5;
    run_instr(16'h0008); run_instr(16'hFCAF);
    chk("am_wr_addr", obs_wa, 16'd8);
    chk("am_wr_data", obs_wd, 16'd4);
    chk("am_pc", pc, 16'd8);
    run_instr(16'hE300);
    chk("am_a", obs_y, 16'd4);

    // random instruction mix
    repeat (250) begin
      if ($urandom_range(0, 2) == 0) ins = {1'b0, 15'($urandom)};
      else                           ins = {3'b111, 13'($urandom)};
      run_instr(ins);
    end

    // reset in the middle of a data read that never completes
    run_instr(16'd20);
    wait_for(0, ok);
    imem_ack = 1'b1; imem_rdata = 16'hFDD0;
    tick();
    imem_ack = 1'b0;
    tick();
    wait_for(1, ok);
    repeat (5) begin
      chk("rst_rd_pending", 16'(dmem_rd_req), 16'd1);
      tick();
    end
    #3 reset = 1'b1;
    #1;
    chk("rst_async_idle", idle_vec(), 16'd0);
    chk("rst_async_pc", pc, 16'h0000);
    repeat (2) tick();
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst2_req", 16'(imem_req), 16'd1);
    chk("rst2_addr", imem_addr, 16'h0000);
    run_instr(16'hE300);
    run_instr(16'h1234); run_instr(16'hE308);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hack_control_unit.md
HACK_CONTROL_UNIT -- requirements
Module: hack_control_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port imem_req, output, 1, instruction fetch request.
REQ-005 SHALL have port imem_addr, output, 16, fetch address (equals PC).
REQ-006 SHALL have port imem_ack, input, 1, fetch complete; imem_rdata is valid this cycle.
REQ-007 SHALL have port imem_rdata, input, 16, instruction word.
REQ-008 SHALL have ports dmem_rd_req and dmem_wr_req, output, 1 each, data read and data write request.
REQ-009 SHALL have ports dmem_addr and dmem_wdata, output, 16 each; dmem_rdata, input, 16; dmem_ack, input, 1.
REQ-010 SHALL have ports alu_x and alu_y, output, 16 each, ALU operands; alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, output, 1 each, ALU control.
REQ-011 SHALL have ports alu_result, input, 16; alu_zr and alu_ng, input, 1 each, ALU result flags.
REQ-012 SHALL have port pc, output, 16, current program counter.

Function
REQ-013 Internal registers SHALL be A, D, PC, IR, M (latched memory operand), RES, ZR and NG; all are 16-bit except the 1-bit flags.
REQ-014 SHALL implement FSM states FETCH, DECODE, MEMRD, EXEC, MEMWR and COMMIT.
REQ-015 FETCH SHALL hold imem_req=1 with imem_addr=PC until imem_ack, then latch IR=imem_rdata and go to DECODE; the earliest exit is the same cycle as imem_req is raised.
REQ-016 DECODE with IR[15]=0 (A-instruction) SHALL load A=IR and PC=PC+1, then go to FETCH; minimum latency is 2 cycles per instruction.
REQ-017 DECODE with IR[15]=1 SHALL go to MEMRD if IR[12]=1 (a-bit, y=M) and to EXEC otherwise.
REQ-018 MEMRD SHALL hold dmem_rd_req=1 with dmem_addr=A until dmem_ack, then latch M=dmem_rdata and go to EXEC.
REQ-019 EXEC SHALL drive alu_x=D, alu_y=(IR[12]?M:A) and {zx,nx,zy,ny,f,no}=IR[11:6] for exactly one cycle, then latch RES=alu_result, ZR=alu_zr and NG=alu_ng.
REQ-020 EXEC SHALL go to MEMWR if IR[3]=1 (dest M) and to COMMIT otherwise.
REQ-021 MEMWR SHALL hold dmem_wr_req=1, dmem_addr=A and dmem_wdata=RES until dmem_ack, then go to COMMIT.
REQ-022 COMMIT SHALL apply the following in the same edge: if IR[5]=1 then A=RES; if IR[4]=1 then D=RES; then go to FETCH.
REQ-023 The jump in COMMIT SHALL be taken when (IR[2]&NG) | (IR[1]&ZR) | (IR[0]&~ZR&~NG); IR[2:0]=111 is always taken.
REQ-024 On a taken jump PC SHALL become the pre-COMMIT value of A, not RES; otherwise PC=PC+1.
REQ-025 PC+1 SHALL wrap from 16'hFFFF to 16'h0000 with no flag.
REQ-026 Outside their owning state, imem_req, dmem_rd_req and dmem_wr_req SHALL be 0; at most one request SHALL be high in any cycle.
REQ-027 The ALU control outputs SHALL be 0 outside EXEC; alu_x and alu_y are don't-care outside EXEC.
REQ-028 Request and address/data outputs SHALL stay stable while a request is pending without ack; the wait is unbounded.
REQ-029 An ack arriving while no request is pending SHALL be ignored.

Reset
REQ-030 While reset=1, the block SHALL immediately force state=FETCH, PC=RESET_PC, A=D=IR=M=RES=0, ZR=NG=0 and all requests=0, including mid-transaction.
REQ-031 After reset deasserts, imem_req SHALL assert on the first cycle with imem_addr=RESET_PC.

Verification
REQ-032 Program @5 (0x0005), D=A (0xEC10), @7, D=D+A (0xE090): the bench SHALL see D=12, A=7 and PC=4 after four instructions.
REQ-033 With A=100 and D=3, instruction M=D (0xE308): the bench SHALL see dmem_wr_req with addr=100 and wdata=3, and D unchanged.
REQ-034 With A=20 and memory[20]=9, instruction D=M+1 (0xFDD0): the bench SHALL see one dmem_rd_req at addr 20 and D=10.
REQ-035 With D=0 and A=0x0040, instruction D;JEQ (0xE302) SHALL set PC=0x0040, and D;JGT (0xE301) SHALL set PC=old PC+1.
REQ-036 Instruction AM=M-1;JMP (0xFCAF) with A=8 and M=5: the bench SHALL see the write to address 8, A=4 and PC=8 (the old A).
REQ-037 Reset asserted during MEMRD with imem_ack/dmem_ack held 0 for 5 cycles: all requests SHALL drop asynchronously and the next fetch SHALL be at RESET_PC.
